// File: rtl/udma_l2_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udma_l2_arb_pkg: shared types for the uDMA L2 port arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package udma_l2_arb_pkg;

  typedef enum logic {
    SIDE_TX = 1'b0,
    SIDE_RX = 1'b1
  } side_e;

  // Tag stored per outstanding L2 transaction
  localparam logic c_tag_read  = 1'b0;
  localparam logic c_tag_write = 1'b1;

endpackage
`default_nettype wire

// File: rtl/udma_l2_tag_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udma_l2_tag_fifo: 1-bit tag FIFO with occupancy count
// Revision: 1.0
// ----------------------------------------------------------------------------
module udma_l2_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     data_i,
  input  logic                     pop_i,
  output logic                     data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/udma_l2_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// udma_l2_port_arbiter: weighted round-robin share of one L2 port (TX/RX)
// Revision: 1.0
// ----------------------------------------------------------------------------
module udma_l2_port_arbiter
  import udma_l2_arb_pkg::*;
#(
  parameter int L2_ADDR_WIDTH   = 32,
  parameter int L2_DATA_WIDTH   = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WEIGHT_W        = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [WEIGHT_W-1:0]               cfg_tx_weight_i,
  input  logic [WEIGHT_W-1:0]               cfg_rx_weight_i,
  input  logic                              tx_req_i,
  input  logic [L2_ADDR_WIDTH-1:0]          tx_addr_i,
  output logic                              tx_gnt_o,
  output logic                              tx_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]          tx_rdata_o,
  input  logic                              rx_req_i,
  input  logic [L2_ADDR_WIDTH-1:0]          rx_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]        rx_be_i,
  input  logic [L2_DATA_WIDTH-1:0]          rx_wdata_i,
  output logic                              rx_gnt_o,
  output logic                              rx_wack_o,
  output logic                              l2_req_o,
  output logic [L2_ADDR_WIDTH-1:0]          l2_addr_o,
  output logic                              l2_we_o,
  output logic [L2_DATA_WIDTH/8-1:0]        l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]          l2_wdata_o,
  input  logic                              l2_gnt_i,
  input  logic                              l2_rvalid_i,
  input  logic [L2_DATA_WIDTH-1:0]          l2_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              err_o
);

  localparam logic [WEIGHT_W-1:0] c_burst_max = '1;

  side_e               r_owner;
  side_e               r_lock_side;
  side_e               w_winner;
  logic                r_lock;
  logic                r_err;
  logic [WEIGHT_W-1:0] r_burst_cnt;
  logic [WEIGHT_W-1:0] w_tx_weight;
  logic [WEIGHT_W-1:0] w_rx_weight;
  logic [WEIGHT_W-1:0] w_owner_weight;
  logic                w_lock_hold;
  logic                w_win_req;
  logic                w_xfer;
  logic                w_full;
  logic                w_empty;
  logic                w_head;

  assign w_tx_weight    = (cfg_tx_weight_i == '0) ? WEIGHT_W'(1) : cfg_tx_weight_i;
  assign w_rx_weight    = (cfg_rx_weight_i == '0) ? WEIGHT_W'(1) : cfg_rx_weight_i;
  assign w_owner_weight = (r_owner == SIDE_TX) ? w_tx_weight : w_rx_weight;

  // A lock only holds while the locked side keeps requesting
  assign w_lock_hold = r_lock & ((r_lock_side == SIDE_TX) ? tx_req_i : rx_req_i);

  always_comb begin
    w_winner = r_owner;
    if (w_lock_hold) begin
      w_winner = r_lock_side;
    end else if (tx_req_i && !rx_req_i) begin
      w_winner = SIDE_TX;
    end else if (rx_req_i && !tx_req_i) begin
      w_winner = SIDE_RX;
    end else if (tx_req_i && rx_req_i) begin
      w_winner = (r_burst_cnt < w_owner_weight) ? r_owner : side_e'(~r_owner);
    end
  end

  assign w_win_req = (w_winner == SIDE_TX) ? tx_req_i : rx_req_i;
  assign l2_req_o  = w_win_req & ~w_full;
  assign w_xfer    = l2_req_o & l2_gnt_i;
  assign tx_gnt_o  = w_xfer & (w_winner == SIDE_TX);
  assign rx_gnt_o  = w_xfer & (w_winner == SIDE_RX);

  always_comb begin
    l2_addr_o  = '0;
    l2_we_o    = 1'b0;
    l2_be_o    = '0;
    l2_wdata_o = '0;
    if (l2_req_o) begin
      if (w_winner == SIDE_RX) begin
        l2_addr_o  = rx_addr_i;
        l2_we_o    = 1'b1;
        l2_be_o    = rx_be_i;
        l2_wdata_o = rx_wdata_i;
      end else begin
        l2_addr_o  = tx_addr_i;
        l2_be_o    = '1;
      end
    end
  end

  udma_l2_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_xfer),
    .data_i  ((w_winner == SIDE_RX) ? c_tag_write : c_tag_read),
    .pop_i   (l2_rvalid_i),
    .data_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (outstanding_o)
  );

  assign tx_rvalid_o = l2_rvalid_i & ~w_empty & (w_head == c_tag_read);
  assign rx_wack_o   = l2_rvalid_i & ~w_empty & (w_head == c_tag_write);
  assign tx_rdata_o  = l2_rdata_i;
  assign err_o       = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner     <= SIDE_TX;
      r_burst_cnt <= '0;
      r_lock      <= 1'b0;
      r_lock_side <= SIDE_TX;
      r_err       <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_winner == r_owner) begin
          if (r_burst_cnt != c_burst_max) r_burst_cnt <= r_burst_cnt + WEIGHT_W'(1);
        end else begin
          r_owner     <= w_winner;
          r_burst_cnt <= WEIGHT_W'(1);
        end
        r_lock <= 1'b0;
      end else if (l2_req_o) begin
        r_lock      <= 1'b1;
        r_lock_side <= w_winner;
      end else begin
        r_lock <= w_lock_hold;
      end
      if (l2_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udma_l2_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_udma_l2_port_arbiter: vector table, directed sequences, random vs model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_udma_l2_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  tw, rw;
  logic        tx_req, rx_req, gnt, rvalid;
  logic [31:0] tx_addr, rx_addr;
  logic [7:0]  rx_be;
  logic [63:0] rx_wdata, rdata;
  logic        tx_gnt_o, tx_rvalid_o, rx_gnt_o, rx_wack_o;
  logic [63:0] tx_rdata_o;
  logic        l2_req_o, l2_we_o, err_o;
  logic [31:0] l2_addr_o;
  logic [7:0]  l2_be_o;
  logic [63:0] l2_wdata_o;
  logic [2:0]  outstanding_o;

  int errors = 0;
  int checks = 0;

  udma_l2_port_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_tx_weight_i (tw),
    .cfg_rx_weight_i (rw),
    .tx_req_i        (tx_req),
    .tx_addr_i       (tx_addr),
    .tx_gnt_o        (tx_gnt_o),
    .tx_rvalid_o     (tx_rvalid_o),
    .tx_rdata_o      (tx_rdata_o),
    .rx_req_i        (rx_req),
    .rx_addr_i       (rx_addr),
    .rx_be_i         (rx_be),
    .rx_wdata_i      (rx_wdata),
    .rx_gnt_o        (rx_gnt_o),
    .rx_wack_o       (rx_wack_o),
    .l2_req_o        (l2_req_o),
    .l2_addr_o       (l2_addr_o),
    .l2_we_o         (l2_we_o),
    .l2_be_o         (l2_be_o),
    .l2_wdata_o      (l2_wdata_o),
    .l2_gnt_i        (gnt),
    .l2_rvalid_i     (rvalid),
    .l2_rdata_i      (rdata),
    .outstanding_o   (outstanding_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       tx_req, rx_req, gnt, rvalid;
    bit [7:0] rdata;
    bit       e_req, e_we, e_tgnt, e_rgnt, e_tval, e_wack;
    int       e_out;
    bit       e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every step begins 1 time unit after a rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_req = 0; rx_req = 0; gnt = 0; rvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  function automatic vec_t mk(input bit tr, rr, g, rv, input bit [7:0] rd,
                              input bit er, ew, etg, erg, etv, ewa,
                              input int eo, input bit ee);
    vec_t v;
    v.tx_req = tr; v.rx_req = rr; v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.e_we = ew; v.e_tgnt = etg; v.e_rgnt = erg;
    v.e_tval = etv; v.e_wack = ewa; v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  // Reference model state
  int m_last, m_run, m_pend;
  bit m_err;
  int tagq[$];

  function automatic int eff(input logic [3:0] w);
    return (w == 0) ? 1 : int'(w);
  endfunction

  initial begin
    //            tx rx g  rv rdata   req we tg rg tv wa out err
    vecs[0]  = mk(0, 0, 0, 0, 8'h00,  0,  0, 0, 0, 0, 0, 0,  0);
    vecs[1]  = mk(1, 0, 1, 0, 8'h00,  1,  0, 1, 0, 0, 0, 0,  0);
    vecs[2]  = mk(1, 0, 1, 0, 8'h00,  1,  0, 1, 0, 0, 0, 1,  0);
    vecs[3]  = mk(1, 0, 1, 1, 8'h11,  1,  0, 1, 0, 1, 0, 2,  0);
    vecs[4]  = mk(0, 1, 1, 1, 8'h22,  1,  1, 0, 1, 1, 0, 2,  0);
    vecs[5]  = mk(1, 0, 1, 0, 8'h00,  1,  0, 1, 0, 0, 0, 2,  0);
    vecs[6]  = mk(1, 0, 1, 0, 8'h00,  1,  0, 1, 0, 0, 0, 3,  0);
    vecs[7]  = mk(1, 0, 1, 0, 8'h00,  0,  0, 0, 0, 0, 0, 4,  0);
    vecs[8]  = mk(1, 0, 1, 1, 8'h33,  0,  0, 0, 0, 1, 0, 4,  0);
    vecs[9]  = mk(1, 0, 0, 1, 8'h44,  1,  0, 0, 0, 0, 1, 3,  0);
    vecs[10] = mk(0, 0, 0, 1, 8'h55,  0,  0, 0, 0, 1, 0, 2,  0);
    vecs[11] = mk(0, 0, 0, 1, 8'h66,  0,  0, 0, 0, 1, 0, 1,  0);
    vecs[12] = mk(0, 0, 0, 1, 8'h77,  0,  0, 0, 0, 0, 0, 0,  0);
    vecs[13] = mk(0, 0, 0, 0, 8'h00,  0,  0, 0, 0, 0, 0, 0,  1);

    tw = 4'd1; rw = 4'd1;
    tx_addr = 32'h100; rx_addr = 32'h200; rx_be = 8'h0F; rx_wdata = 64'hDEAD;
    rdata = 64'hABCD;
    idle_inputs();
    rst = 1;
    #3;
    // Reset state with no requests
    chk("rst_l2_req", l2_req_o, 0);
    chk("rst_l2_addr", l2_addr_o, 0);
    chk("rst_l2_we_be", {l2_we_o, l2_be_o}, 0);
    chk("rst_l2_wdata", l2_wdata_o, 0);
    chk("rst_gnts_resp", {tx_gnt_o, rx_gnt_o, tx_rvalid_o, rx_wack_o}, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata_pass", tx_rdata_o, 64'hABCD);
    next_cycle();
    rst = 0;

    // Vector table: TX-only, full, mixed routing, empty-FIFO error
    for (int i = 0; i < 14; i++) begin
      tx_req = vecs[i].tx_req; rx_req = vecs[i].rx_req;
      gnt = vecs[i].gnt; rvalid = vecs[i].rvalid; rdata = {56'd0, vecs[i].rdata};
      #4;
      chk($sformatf("vec%0d_req", i), l2_req_o, vecs[i].e_req);
      chk($sformatf("vec%0d_gnts", i), {tx_gnt_o, rx_gnt_o}, {vecs[i].e_tgnt, vecs[i].e_rgnt});
      chk($sformatf("vec%0d_resp", i), {tx_rvalid_o, rx_wack_o}, {vecs[i].e_tval, vecs[i].e_wack});
      chk($sformatf("vec%0d_out", i), outstanding_o, 64'(vecs[i].e_out));
      chk($sformatf("vec%0d_err", i), err_o, vecs[i].e_err);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d_we", i), l2_we_o, vecs[i].e_we);
        chk($sformatf("vec%0d_addr", i), l2_addr_o, vecs[i].e_we ? 32'h200 : 32'h100);
      end
      if (vecs[i].rvalid) chk($sformatf("vec%0d_rdata", i), tx_rdata_o, {56'd0, vecs[i].rdata});
      next_cycle();
    end
    chk("err_sticky", err_o, 1);

    // Weighted sharing 3:1 then weights 0:0 behaving as 1:1
    for (int pass = 0; pass < 2; pass++) begin
      bit [7:0] exp_rx;
      do_reset();
      tw = (pass == 0) ? 4'd3 : 4'd0;
      rw = (pass == 0) ? 4'd1 : 4'd0;
      exp_rx = (pass == 0) ? 8'b1000_1000 : 8'b1010_1010;
      tx_req = 1; rx_req = 1; gnt = 1;
      for (int i = 0; i < 8; i++) begin
        rvalid = (i > 0);
        #4;
        chk($sformatf("wrr%0d_%0d", pass, i), {tx_gnt_o, rx_gnt_o}, {~exp_rx[i], exp_rx[i]});
        next_cycle();
      end
    end
    tw = 4'd1; rw = 4'd1;

    // Lock: TX stalled by L2 keeps the port although RX would win unlocked
    do_reset();
    tx_req = 1; gnt = 1; #4; chk("lock_pre_gnt", tx_gnt_o, 1); next_cycle();
    gnt = 0; #4; chk("lock_set_req", l2_req_o, 1); next_cycle();
    rx_req = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("lock_addr%0d", i), l2_addr_o, 32'h100);
      chk($sformatf("lock_we%0d", i), l2_we_o, 0);
      next_cycle();
    end
    gnt = 1; #4; chk("lock_release_gnt", {tx_gnt_o, rx_gnt_o}, 2'b10); next_cycle();
    #4; chk("lock_rx_after", {tx_gnt_o, rx_gnt_o, l2_we_o}, 3'b011); next_cycle();
    rx_req = 0; gnt = 0; #4; chk("lock2_set", l2_we_o, 0); next_cycle();
    tx_req = 0; rx_req = 1; #4;
    chk("lock_drop_switch", {l2_req_o, l2_we_o, l2_addr_o}, {2'b11, 32'h200});
    next_cycle();

    // Reset mid-burst with two transactions outstanding
    do_reset();
    tx_req = 1; gnt = 1; next_cycle(); next_cycle();
    #2; chk("burst_out2", outstanding_o, 2);
    idle_inputs();
    rst = 1;
    #1;
    chk("async_rst_out", outstanding_o, 0);
    chk("async_rst_err_req", {err_o, l2_req_o}, 0);
    next_cycle();
    rst = 0;
    rvalid = 1; #4;
    chk("stale_rvalid_quiet", {tx_rvalid_o, rx_wack_o}, 0);
    next_cycle();
    rvalid = 0; #4;
    chk("stale_rvalid_err", err_o, 1);
    next_cycle();

    // Random traffic against a transaction-level model
    do_reset();
    m_last = 0; m_run = 0; m_pend = -1; m_err = 0;
    tagq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  win;
      bit  pend_ok, e_req, e_tval, e_wack;
      if (cyc % 250 == 0) begin
        tw = 4'($urandom_range(0, 15));
        rw = 4'($urandom_range(0, 15));
      end
      tx_req   = ($urandom_range(0, 9) < 7);
      rx_req   = ($urandom_range(0, 9) < 7);
      gnt      = ($urandom_range(0, 9) < 6);
      tx_addr  = $urandom;
      rx_addr  = $urandom;
      rx_be    = 8'($urandom);
      rx_wdata = {$urandom, $urandom};
      rdata    = {$urandom, $urandom};
      rvalid   = (tagq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);

      pend_ok = (m_pend >= 0) && ((m_pend == 0) ? tx_req : rx_req);
      if (pend_ok) win = m_pend;
      else if (tx_req && !rx_req) win = 0;
      else if (rx_req && !tx_req) win = 1;
      else if (tx_req && rx_req)
        win = (m_run < eff((m_last == 0) ? tw : rw)) ? m_last : 1 - m_last;
      else win = -1;
      e_req  = (win >= 0) && (tagq.size() < 4);
      e_tval = rvalid && (tagq.size() > 0) && (tagq[0] == 0);
      e_wack = rvalid && (tagq.size() > 0) && (tagq[0] == 1);

      #4;
      chk("rnd_req", l2_req_o, e_req);
      chk("rnd_gnts", {tx_gnt_o, rx_gnt_o},
          {e_req && gnt && win == 0, e_req && gnt && win == 1});
      if (e_req) begin
        chk("rnd_addr", l2_addr_o, (win == 0) ? tx_addr : rx_addr);
        chk("rnd_we_be", {l2_we_o, l2_be_o}, (win == 0) ? 9'h0FF : {1'b1, rx_be});
        chk("rnd_wdata", l2_wdata_o, (win == 0) ? 64'd0 : rx_wdata);
      end
      chk("rnd_resp", {tx_rvalid_o, rx_wack_o}, {e_tval, e_wack});
      if (e_tval) chk("rnd_rdata", tx_rdata_o, rdata);
      chk("rnd_out", outstanding_o, 64'(tagq.size()));
      chk("rnd_err", err_o, m_err);

      if (rvalid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else m_err = 1;
      end
      if (e_req && gnt) begin
        tagq.push_back(win);
        if (win == m_last) m_run = (m_run < 15) ? m_run + 1 : 15;
        else begin
          m_last = win;
          m_run  = 1;
        end
        m_pend = -1;
      end else if (e_req) begin
        m_pend = win;
      end else if (!pend_ok) begin
        m_pend = -1;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
